hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. Register-match flags feed it.
//  From those it drives PC/IF_ID write enables, ID_EX bubble, IF_ID flush, full freeze and EX forwarding selects.
//  Tracks memory-wait freezes with a timeout and keeps saturating stall/flush/freeze counters.
// PARAMETERS
//  MAX_WAIT  16  max consecutive mem_busy cycles before sticky error (>=1)
//  CNT_W     16  width of each performance counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  IF_ID_rs1/rs2  in   5 ea   source regs of instruction in ID
//  id_use_rs1/2   in   1 ea   ID instruction actually reads rs1/rs2
//  ID_EX_rs1/rs2  in   5 ea   source regs of instruction in EX (forwarding)
//  ID_EX_rd       in   5      dest of EX instr; ID_EX_regwrite, ID_EX_memread in 1 ea
//  EX_MEM_rd      in   5      dest of MEM instr; EX_MEM_regwrite in 1
//  MEM_WB_rd      in   5      dest of WB instr; MEM_WB_regwrite in 1
//  branch_taken   in   1      branch/jump resolved taken in EX
//  mem_busy       in   1      data memory not ready this cycle
//  pc_we, if_id_we out 1 ea   PC / IF_ID register write enables
//  if_id_flush    out  1      load NOP into IF_ID
//  id_ex_flush    out  1      load bubble into ID_EX
//  pipe_freeze    out  1      hold ID_EX, EX_MEM, MEM_WB
//  fwd_a/b_sel    out  2 ea   EX operand source: 00 RF, 10 EX_MEM, 01 MEM_WB
//  stall_cnt, flush_cnt, freeze_cnt  out CNT_W ea  saturating event counters
//  err            out  1      sticky timeout error
// BEHAVIOUR
//  Match rule: rd==x0 never matches; match needs the stage's regwrite=1 and the use flag.
//  All control outputs are combinational from inputs + state (same-cycle response); counters/state are registered.
//  States: RUN, FREEZE, HALT. Reset -> RUN, counters 0, err 0.
//  Reset values: pc_we=if_id_we=1; flushes=0; pipe_freeze=0; fwd sels=00.
//  Priority in RUN/FREEZE: mem_busy > branch_taken > load-use stall.
//  mem_busy=1: pc_we=if_id_we=0, pipe_freeze=1, no flush.
//  RUN->FREEZE on mem_busy; wait_cnt counts cycles in FREEZE.
//  FREEZE->RUN the cycle mem_busy=0.
//  FREEZE->HALT when wait_cnt reaches MAX_WAIT with mem_busy still 1; err<=1.
//  HALT: pc_we=if_id_we=0, pipe_freeze=1 forever until rst; counters hold.
//  branch_taken (not busy): if_id_flush=id_ex_flush=1, pc_we=1; load-use ignored (wrong path).
//  Load-use (not busy, no branch): ID_EX_memread and ID_EX_rd matches rs1/rs2.
//    Load-use response: pc_we=if_id_we=0, id_ex_flush=1 for exactly that cycle.
//  Forwarding: EX_MEM match on ID_EX_rsN -> 10.
//    else MEM_WB match -> 01, else 00. EX_MEM wins when both match.
//  Counters +1 per stall/flush/freeze cycle, saturate at all-ones, no wrap.
//  Reset mid-FREEZE or in HALT -> RUN, err cleared.
// CONFIGURATION
//  HAZ_FWD_EN defined: forwarding as above; only load-use stalls.
//  HAZ_FWD_EN undefined: fwd sels tied 00.
//    Any ID match against ID_EX_rd or EX_MEM_rd stalls like load-use. MEM_WB relies on write-first RF.
// STRUCTURE
//  hazard_pkg: fwd_sel_t enum (FWD_RF, FWD_EX_MEM, FWD_MEM_WB), haz_state_t enum, REG_X0 constant.
//  One sub-module reg_match: 5-bit src vs rd with regwrite/x0 qualification, instanced per comparison.
// TESTING
//  ID_EX_memread=1, ID_EX_rd=5, IF_ID_rs1=5, use=1 -> one cycle pc_we=0, id_ex_flush=1, stall_cnt=1.
//  Same as above with ID_EX_rd=0 -> no stall.
//  EX_MEM_rd=MEM_WB_rd=7, ID_EX_rs2=7, both regwrite -> fwd_b_sel=10 (00 if HAZ_FWD_EN undefined).
//  branch_taken plus load-use in the same cycle -> both flushes=1, pc_we=1, stall_cnt unchanged.
//  mem_busy for 3 cycles -> freeze 3 cycles, RUN next, freeze_cnt=3, err=0.
//  mem_busy held, MAX_WAIT=4 -> HALT, err=1 and sticky; rst -> RUN, err=0, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional build macro HAZ_FWD_EN (see hazard_ctrl.sv) does not affect this package.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EX_MEM = 2'b10,
    FWD_MEM_WB = 2'b01
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FREEZE,
    ST_HALT
  } haz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // The younger producer (EX_MEM) holds the newer value, so it wins.
  function automatic fwd_sel_t fwd_pick(input logic em_hit, input logic wb_hit);
    if (em_hit) return FWD_EX_MEM;
    if (wb_hit) return FWD_MEM_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: register-match inputs and control outputs.
// master = pipeline side, slave = hazard_ctrl. Macro HAZ_FWD_EN does not change the port set.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  logic [4:0]       IF_ID_rs1, IF_ID_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic [4:0]       ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic             ID_EX_regwrite, ID_EX_memread;
  logic [4:0]       EX_MEM_rd;
  logic             EX_MEM_regwrite;
  logic [4:0]       MEM_WB_rd;
  logic             MEM_WB_regwrite;
  logic             branch_taken, mem_busy;

  logic             pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze;
  fwd_sel_t         fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic             err;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, id_use_rs1, id_use_rs2,
           ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
           EX_MEM_rd, EX_MEM_regwrite, MEM_WB_rd, MEM_WB_regwrite,
           branch_taken, mem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, freeze_cnt, err
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, id_use_rs1, id_use_rs2,
           ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
           EX_MEM_rd, EX_MEM_regwrite, MEM_WB_rd, MEM_WB_regwrite,
           branch_taken, mem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, freeze_cnt, err
  );

endinterface

// File: rtl/hazard_ctrl_reg_match.sv
// One qualified register comparison: source vs destination, gated by regwrite,
// the consumer's use flag, and x0 exclusion.
module reg_match
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] rd,
  input  logic       regwrite,
  input  logic       use_src,
  output logic       match
);

  assign match = use_src && regwrite && (rd != REG_X0) && (src == rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/freeze/forward control with mem-wait timeout and counters.
// Build macro HAZ_FWD_EN: defined -> EX forwarding + load-use stalls only; undefined -> no forwarding, stall on EX/MEM producers.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int               WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0] id_src [2];
  logic [1:0] id_use;
  logic [1:0] id_ex_hit;
  fwd_sel_t   fwd_sel [2];
  logic       data_hazard;

  assign id_src[0] = bus.IF_ID_rs1;
  assign id_src[1] = bus.IF_ID_rs2;
  assign id_use    = {bus.id_use_rs2, bus.id_use_rs1};

`ifdef HAZ_FWD_EN
  logic [4:0] ex_src [2];
  assign ex_src[0] = bus.ID_EX_rs1;
  assign ex_src[1] = bus.ID_EX_rs2;
`else
  logic [1:0] id_em_hit;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      reg_match u_id_ex (
        .src      (id_src[gi]),
        .rd       (bus.ID_EX_rd),
        .regwrite (bus.ID_EX_regwrite),
        .use_src  (id_use[gi]),
        .match    (id_ex_hit[gi])
      );
`ifdef HAZ_FWD_EN
      logic em_hit, wb_hit;
      reg_match u_fwd_em (
        .src      (ex_src[gi]),
        .rd       (bus.EX_MEM_rd),
        .regwrite (bus.EX_MEM_regwrite),
        .use_src  (1'b1),
        .match    (em_hit)
      );
      reg_match u_fwd_wb (
        .src      (ex_src[gi]),
        .rd       (bus.MEM_WB_rd),
        .regwrite (bus.MEM_WB_regwrite),
        .use_src  (1'b1),
        .match    (wb_hit)
      );
      assign fwd_sel[gi] = fwd_pick(em_hit, wb_hit);
`else
      reg_match u_id_em (
        .src      (id_src[gi]),
        .rd       (bus.EX_MEM_rd),
        .regwrite (bus.EX_MEM_regwrite),
        .use_src  (id_use[gi]),
        .match    (id_em_hit[gi])
      );
      assign fwd_sel[gi] = FWD_RF;
`endif
    end
  endgenerate

`ifdef HAZ_FWD_EN
  assign data_hazard = bus.ID_EX_memread && (|id_ex_hit);
`else
  // Without bypass paths any in-flight producer must drain; MEM_WB is covered by a write-first RF.
  assign data_hazard = (|id_ex_hit) || (|id_em_hit);
`endif

  haz_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  logic pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;

    if (state_q == ST_HALT) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      pipe_freeze = 1'b1;
    end else if (bus.mem_busy) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      pipe_freeze  = 1'b1;
      freeze_cnt_d = sat_inc(freeze_cnt_q);
      // wait_q = busy cycles already seen; MAX_WAIT of them are tolerated.
      if (state_q == ST_RUN) begin
        state_d = ST_FREEZE;
        wait_d  = WAIT_W'(1);
      end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      state_d = ST_RUN;
      wait_d  = '0;
      if (bus.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (data_hazard) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end

    if (rst) begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      wait_q       <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.if_id_we    = if_id_we;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.pipe_freeze = pipe_freeze;
  assign bus.fwd_a_sel   = rst ? FWD_RF : fwd_sel[0];
  assign bus.fwd_b_sel   = rst ? FWD_RF : fwd_sel[1];
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.freeze_cnt  = freeze_cnt_q;
  assign bus.err         = err_q;

endmodule
